// File: rtl/pipeline_hazard_if.sv
// Stall/flush control bundle between the pipeline datapath and the hazard controller.
// The master side owns the ID/EX hazard sources; the slave side drives the controls.
interface pipeline_hazard_if #(
    parameter int COUNT_W = 32
);
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic [4:0]         ex_rd;
    logic               ex_wb_load;
    logic               ex_jump_en;
    logic               ex_div_op;
    logic               div_done;
    logic               pc_stall;
    logic               if_id_stall;
    logic               if_id_flush;
    logic               id_ex_stall;
    logic               id_ex_flush;
    logic               ex_mem_flush;
    logic               div_start;
    logic               ex_div_result_sel;
    logic               busy;
    logic               div_timeout;
    logic [COUNT_W-1:0] stall_count;
    logic [COUNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_wb_load,
               ex_jump_en, ex_div_op, div_done,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_flush, div_start, ex_div_result_sel, busy, div_timeout,
               stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_wb_load,
               ex_jump_en, ex_div_op, div_done,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_flush, div_start, ex_div_result_sel, busy, div_timeout,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, jump flushes and
// the start/busy/done handshake with the iterative divider, plus stall/flush counters.
module pipeline_hazard_controller #(
    parameter int DIV_TIMEOUT = 64,
    parameter int TO_W        = 7,
    parameter int COUNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_hazard_if.slave  hz
);
    typedef enum logic [1:0] {RUN, DIV_BUSY, DIV_DONE} state_e;

    state_e             state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               div_timeout_q, div_timeout_d;
    logic [COUNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_flush, div_start, result_sel, busy;
    logic load_use;

    assign load_use = hz.ex_wb_load && (hz.ex_rd != 5'd0) &&
                      ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        div_timeout_d = div_timeout_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        div_start     = 1'b0;
        result_sel    = 1'b0;
        busy          = 1'b0;
        unique case (state_q)
            RUN: begin
                // Jump beats divide beats load-use; a jump squashes the divide in EX.
                if (hz.ex_jump_en) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hz.ex_div_op) begin
                    div_start    = 1'b1;
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    to_cnt_d     = '0;
                    state_d      = DIV_BUSY;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            DIV_BUSY: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                busy         = 1'b1;
                to_cnt_d     = to_cnt_q + TO_W'(1);
                if (hz.div_done) begin
                    state_d = DIV_DONE;
                end else if (to_cnt_q == TO_W'(DIV_TIMEOUT - 1)) begin
                    div_timeout_d = 1'b1;
                    state_d       = DIV_DONE;
                end
            end
            DIV_DONE: begin
                result_sel = 1'b1;
                busy       = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            to_cnt_q      <= '0;
            div_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            div_timeout_q <= div_timeout_d;
            if (pc_stall)    stall_cnt_q <= stall_cnt_q + COUNT_W'(1);
            if (if_id_flush) flush_cnt_q <= flush_cnt_q + COUNT_W'(1);
        end
    end

    assign hz.pc_stall          = pc_stall;
    assign hz.if_id_stall       = if_id_stall;
    assign hz.if_id_flush       = if_id_flush;
    assign hz.id_ex_stall       = id_ex_stall;
    assign hz.id_ex_flush       = id_ex_flush;
    assign hz.ex_mem_flush      = ex_mem_flush;
    assign hz.div_start         = div_start;
    assign hz.ex_div_result_sel = result_sel;
    assign hz.busy              = busy;
    assign hz.div_timeout       = div_timeout_q;
    assign hz.stall_count       = stall_cnt_q;
    assign hz.flush_count       = flush_cnt_q;
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32IM pipeline. Detects load-use hazards between ID and EX, flushes the wrong-path instructions on EX-resolved jumps/branches, and sequences multi-cycle M-extension divides. A divide holds the pipeline in a start/busy/done handshake with an external iterative divider. The block drives the hold/flush controls of the fetch stage and the IF/ID, ID/EX and EX/MEM pipeline registers, and keeps stall and flush performance counters.

Parameters:
DIV_TIMEOUT, 64, max cycles in DIV_BUSY before abort; must be >= 2.
TO_W, 7, timeout counter width; must satisfy 2^TO_W > DIV_TIMEOUT.
COUNT_W, 32, width of the performance counters.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
id_rs1  input  5  rs1 of the instruction in ID
id_rs2  input  5  rs2 of the instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_rd  input  5  destination register of the instruction in EX
ex_wb_load  input  1  EX instruction is a load
ex_jump_en  input  1  EX resolved a taken branch or jump
ex_div_op  input  1  EX instruction is DIV/DIVU/REM/REMU
div_done  input  1  divider result valid (single-cycle pulse)
pc_stall  output  1  hold the PC
if_id_stall  output  1  hold the IF/ID register
if_id_flush  output  1  load NOP into IF/ID
id_ex_stall  output  1  hold the ID/EX register
id_ex_flush  output  1  load a bubble into ID/EX
ex_mem_flush  output  1  load a bubble into EX/MEM
div_start  output  1  one-cycle start pulse to the divider
ex_div_result_sel  output  1  EX/MEM captures the divider result instead of the ALU result
busy  output  1  FSM is not in RUN
div_timeout  output  1  sticky: a divide was aborted on timeout
stall_count  output  COUNT_W  cycles with pc_stall=1, wraps
flush_count  output  COUNT_W  cycles with if_id_flush=1, wraps

Behaviour:
- Reset (async, any state): state=RUN, timeout counter=0, div_timeout=0, stall_count=0, flush_count=0. All control outputs are 0 while inputs are idle.
- The FSM has three states: RUN, DIV_BUSY, DIV_DONE. All control outputs are combinational from state and inputs; state and counters update on the rising edge of clk.
- RUN, priority 1: ex_jump_en=1 gives if_id_flush=1 and id_ex_flush=1, with no stall. A jump overrides any load-use hazard and cannot coincide with ex_div_op; if it does, the jump wins and no divide starts.
- RUN, priority 2: ex_div_op=1 gives div_start=1, pc_stall=1, if_id_stall=1, id_ex_stall=1 and ex_mem_flush=1. The next state is DIV_BUSY and the timeout counter is loaded with 0.
- RUN, priority 3 (load-use): fires when ex_wb_load=1, ex_rd!=0 and (id_rs1_used and id_rs1==ex_rd, or id_rs2_used and id_rs2==ex_rd). Outputs are pc_stall=1, if_id_stall=1 and id_ex_flush=1 for exactly one cycle, then the hazard clears naturally.
- RUN, otherwise: all outputs are 0.
- DIV_BUSY:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_flush are held at 1, and busy=1.
  - ex_jump_en and load-use conditions are ignored.
  - The timeout counter increments every cycle.
  - div_done=1 moves the FSM to DIV_DONE.
  - If div_done is not seen and the counter reaches DIV_TIMEOUT-1, div_timeout is set to 1 and the FSM moves to DIV_DONE.
- DIV_DONE: one cycle only. ex_div_result_sel=1, busy=1, no stall or flush, so the pipeline advances. The next state is RUN.
- Back-to-back divides: a second divide reaching EX after DIV_DONE starts a new sequence from RUN, with a one-cycle gap.
- div_done received outside DIV_BUSY is ignored.
- Counters:
  - stall_count increments on every cycle with pc_stall=1, including the div_start cycle.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both wrap to 0 after 2^COUNT_W-1.
  - div_timeout clears only on rst.
- Divide latency from div_start to ex_div_result_sel is 1 + (cycles in DIV_BUSY) cycles.

Test Plan:
- Reset asserted mid-DIV_BUSY, asynchronously between edges -> all outputs 0 immediately, busy=0, both counters 0, div_timeout=0.
- Load-use hazard: ex_wb_load=1, ex_rd=5, id_rs2_used=1, id_rs2=5 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1. Same stimulus with ex_rd=0 -> no stall.
- Jump plus load-use in the same cycle -> only if_id_flush=id_ex_flush=1, pc_stall=0, flush_count +1.
- Divide: ex_div_op=1 at cycle 0, div_done pulse at cycle 10 -> div_start at cycle 0 only, stalls in cycles 0-10, ex_div_result_sel=1 at cycle 11, stall_count=11.
- Divide timeout: div_done never asserted, DIV_TIMEOUT=64 -> div_timeout=1 after 64 cycles in DIV_BUSY, then one DIV_DONE cycle, then RUN.
- Counter wrap: COUNT_W=4 with 17 consecutive stall cycles -> stall_count=1.
